// File: rtl/mdiv_unit_if.sv
// Launch/result bundle between the execute stage and the iterative multiply/divide unit.
// The master side issues operations; the slave side returns BUSY and the HI/LO registers.
interface mdiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, op, src_a, src_b, input busy, hi, lo);
  modport slave  (input start, op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/mdiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers on a shared 2*XLEN shift register.
// Optional MDIV_FAST_MUL_EN: single-cycle multiply written at the START edge; divide stays iterative.
module mdiv_unit #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mdiv_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic              is_div_q, is_div_d;
  logic              busy_q;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  // Operand conditioning at launch: magnitudes plus the sign flags that FIX reapplies.
  logic            mt_go, md_go, is_signed, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;

  assign mt_go     = bus.start && (bus.op == OP_MTHI || bus.op == OP_MTLO);
  assign md_go     = bus.start && !bus.op[2];
  assign is_signed = !bus.op[0];
  assign sign_a    = is_signed && bus.src_a[XLEN-1];
  assign sign_b    = is_signed && bus.src_b[XLEN-1];
  assign mag_a     = sign_a ? -bus.src_a : bus.src_a;
  assign mag_b     = sign_b ? -bus.src_b : bus.src_b;

`ifdef MDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_raw, fast_prod;
  assign fast_raw  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fast_prod = (sign_a ^ sign_b) ? -fast_raw : fast_raw;
`endif

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rem;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod;

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_sum   = '0;
    div_rem   = '0;
    div_trial = '0;
    prod      = '0;

    if (mt_go) begin
      // A move-to aborts any in-flight op so a later FIX cannot clobber it.
      if (bus.op == OP_MTHI) hi_d = bus.src_a;
      else                   lo_d = bus.src_a;
      state_d = IDLE;
    end else if (md_go) begin
      state_d   = bus.op[1] ? DIV : MUL;
      cnt_d     = CW'(XLEN-1);
      acc_d     = {{XLEN{1'b0}}, mag_a};
      dvs_d     = mag_b;
      a_raw_d   = bus.src_a;
      neg_res_d = sign_a ^ sign_b;
      neg_rem_d = sign_a;
      dz_d      = bus.op[1] && (bus.src_b == '0);
      is_div_d  = bus.op[1];
`ifdef MDIV_FAST_MUL_EN
      if (!bus.op[1]) begin
        hi_d    = fast_prod[2*XLEN-1:XLEN];
        lo_d    = fast_prod[XLEN-1:0];
        state_d = IDLE;
      end
`endif
    end else begin
      case (state_q)
        MUL: begin
          mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + {1'b0, (acc_q[0] ? dvs_q : {XLEN{1'b0}})};
          acc_d   = {mul_sum, acc_q[XLEN-1:1]};
        end
        DIV: begin
          div_rem   = acc_q[2*XLEN-1:XLEN-1];
          div_trial = div_rem - {1'b0, dvs_q};
          if (!div_trial[XLEN]) acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                  acc_d = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        FIX: begin
          if (is_div_q) begin
            if (dz_q) begin
              lo_d = '1;
              hi_d = a_raw_q;
            end else begin
              lo_d = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
              hi_d = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            end
          end else begin
            prod = neg_res_q ? -acc_q : acc_q;
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
          end
          state_d = IDLE;
        end
        default: ;
      endcase

      if (state_q == MUL || state_q == DIV) begin
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments and clears asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      dvs_q     <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      is_div_q  <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      a_raw_q   <= a_raw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      is_div_q  <= is_div_d;
      busy_q    <= (state_d != IDLE);
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdiv_unit.sv
// Self-checking bench for mdiv_unit: directed corner cases, aborts, async reset and random ops
// against an arithmetic reference model of HI/LO.
module tb_mdiv_unit;
  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdiv_unit_if #(.XLEN(XLEN)) bus ();
  mdiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero like the ISA.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, tq, tr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; mdl_hi = p[63:32]; mdl_lo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; mdl_hi = p[63:32]; mdl_lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          mdl_lo = 32'hFFFF_FFFF;
          mdl_hi = a;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          tq = q; tr = r;
          mdl_lo = tq[31:0]; mdl_hi = tr[31:0];
        end else begin
          mdl_lo = a / b; mdl_hi = a % b;
        end
      end
      3'd4: mdl_hi = a;
      3'd5: mdl_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int busy_len(input logic [2:0] op);
`ifdef MDIV_FAST_MUL_EN
    if (op == 3'd0 || op == 3'd1) return 0;
`endif
    return (op[2] == 1'b0) ? XLEN + 1 : 0;
  endfunction

  // Called at a negedge; returns at the negedge after the START edge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b111;
  endtask

  // Counts busy cycles from the current sample onward; prior HI/LO must hold meanwhile.
  task automatic wait_idle(input logic [31:0] old_hi, input logic [31:0] old_lo,
                           inout int n, output bit hold_ok);
    hold_ok = 1'b1;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.hi !== old_hi || bus.lo !== old_lo) hold_ok = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string name);
    checks++;
    if (bus.hi !== mdl_hi) begin
      errors++; $display("FAIL %s hi: got %h expected %h", name, bus.hi, mdl_hi);
    end
    checks++;
    if (bus.lo !== mdl_lo) begin
      errors++; $display("FAIL %s lo: got %h expected %h", name, bus.lo, mdl_lo);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [31:0] old_hi, old_lo;
    int n, exp_n;
    bit hold_ok;
    old_hi = mdl_hi; old_lo = mdl_lo;
    model(op, a, b);
    exp_n = busy_len(op);
    n = 0;
    launch(op, a, b);
    wait_idle(old_hi, old_lo, n, hold_ok);
    checks++;
    if (n != exp_n) begin
      errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_n);
    end
    if (exp_n > 0) begin
      checks++;
      if (!hold_ok) begin
        errors++; $display("FAIL %s hold: HI/LO changed before completion (expected %h/%h)", name, old_hi, old_lo);
      end
    end
    check_result(name);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++; $display("FAIL reset: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7,         "mult_neg3x7");
    run_op(3'd3, 32'd100,       32'd7,         "divu_100_7");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2,         "div_m7_2");
    run_op(3'd3, 32'h0000_1234, 32'd0,         "divu_by_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(3'd4, 32'hCAFE_0001, 32'd0,         "mthi");
    run_op(3'd5, 32'hBEEF_0002, 32'd0,         "mtlo");
    run_op(3'd6, 32'h1111_1111, 32'd3,         "noop");
  endtask

  task automatic test_abort();
    logic [31:0] old_hi, old_lo;
    logic [2:0] first_op;
    int n;
    bit hold_ok, cont;
`ifdef MDIV_FAST_MUL_EN
    first_op = 3'd2;
`else
    first_op = 3'd0;
`endif
    // Restart: second op issued at cycle 10 of the first; BUSY must not drop.
    launch(first_op, 32'd123, 32'd45);
    cont = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (bus.busy !== 1'b1) cont = 1'b0;
      @(negedge clk);
    end
    old_hi = mdl_hi; old_lo = mdl_lo;
    model(3'd3, 32'd9, 32'd4);
    n = 0;
    launch(3'd3, 32'd9, 32'd4);
    wait_idle(old_hi, old_lo, n, hold_ok);
    checks++;
    if (!cont || n != XLEN + 1) begin
      errors++; $display("FAIL restart_busy: continuous=%b cycles=%0d expected 1/%0d", cont, n, XLEN + 1);
    end
    check_result("restart_divu_9_4");

    // No-op mid-divide neither aborts nor perturbs the result.
    old_hi = mdl_hi; old_lo = mdl_lo;
    model(3'd2, 32'hFFFF_FC18, 32'd7);
    n = 0;
    launch(3'd2, 32'hFFFF_FC18, 32'd7);
    for (int i = 0; i < 4; i++) begin
      if (bus.busy === 1'b1) n++;
      @(negedge clk);
    end
    launch(3'b110, 32'hDEAD_BEEF, 32'd1);
    n++;
    wait_idle(old_hi, old_lo, n, hold_ok);
    checks++;
    if (n != XLEN + 1 || !hold_ok) begin
      errors++; $display("FAIL noop_mid_div: cycles=%0d hold=%b expected %0d/1", n, hold_ok, XLEN + 1);
    end
    check_result("noop_mid_div");

    // MTLO mid-divide: immediate write, BUSY drops, no later overwrite.
    launch(3'd3, 32'd5000, 32'd3);
    for (int i = 0; i < 5; i++) @(negedge clk);
    model(3'd5, 32'h55, 32'd0);
    launch(3'd5, 32'h55, 32'd0);
    checks++;
    if (bus.lo !== 32'h55 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mtlo_mid_div: lo=%h busy=%b expected 00000055/0", bus.lo, bus.busy);
    end
    for (int i = 0; i < 40; i++) @(negedge clk);
    check_result("mtlo_no_overwrite");
  endtask

  task automatic test_reset_mid_op();
    run_op(3'd4, 32'hA5A5_A5A5, 32'd0, "pre_reset_mthi");
    run_op(3'd5, 32'h5A5A_5A5A, 32'd0, "pre_reset_mtlo");
    launch(3'd2, 32'd77, 32'd5);
    for (int i = 0; i < 14; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++; $display("FAIL async_reset: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    mdl_hi = '0; mdl_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd0, 32'd6, 32'd7, "post_reset_mult_6x7");
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      run_op(op, a, b, $sformatf("random_%0d_op%0d", i, op));
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'b111; bus.src_a = '0; bus.src_b = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_directed();
    test_abort();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mdiv_unit.md
Name: mdiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. Instructions are launched from the execute stage. The unit produces the MDIV_BUSY_M indication that the hazard unit uses to stall MFHI/MFLO. It also supplies HI/LO to the MFCOP read mux in M.
Signed and unsigned 32x32 multiply, 32/32 divide and MTHI/MTLO are supported; the datapath is a shared 64-bit shift register.

Parameters:
XLEN, 32, operand/HI/LO width; counter is clog2(XLEN) bits.

Ports:
CLK  input  1  clock, rising edge.
RESET_N  input  1  asynchronous, active-low reset.
START  input  1  launch OP this cycle (qualified by E-stage valid, not stalled).
OP  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
SRC_A  input  XLEN  rs value (dividend / multiplicand / MTHI-MTLO data).
SRC_B  input  XLEN  rt value (divisor / multiplier).
BUSY  output  1  operation in flight; drives MDIV_BUSY_M.
HI  output  XLEN  architectural HI register.
LO  output  XLEN  architectural LO register.

Behaviour:
- Reset: state IDLE; BUSY=0, HI=0, LO=0; counter, shift register and sign flags cleared. Async assert, sync release.
- States: IDLE, MUL, DIV, FIX.
- All outputs are registered; none is combinational from inputs.
- IDLE + START + OP=MTHI/MTLO: the selected register gets SRC_A at that edge. No state change; BUSY stays 0.
- START + OP=MULT/MULTU/DIV/DIVU:
  - Latch magnitudes. For signed ops, take abs of each operand; for unsigned ops, use operands as-is.
  - Latch sign flags: neg_res = sign(A)^sign(B), neg_rem = sign(A). Both are 0 for unsigned ops.
  - Counter = XLEN-1; go to MUL or DIV; BUSY=1 from the next cycle.
- MUL: one shift-add step per cycle; 64-bit accumulator, multiplier consumed LSB first.
- DIV: restoring radix-2, one quotient bit per cycle; remainder in upper half, quotient shifted into lower half.
- MUL/DIV exit: the cycle the counter reads 0 goes to FIX. That is XLEN iteration cycles.
- FIX: apply signs to the raw result.
  - Product: negated as 64 bits if neg_res; HI=upper half, LO=lower half.
  - Quotient: negated if neg_res; written to LO.
  - Remainder: negated if neg_rem; written to HI.
  - HI/LO are written at the end of FIX; BUSY falls on the same edge; state returns to IDLE.
- Latency: BUSY is high for exactly XLEN+1 = 33 cycles after the START edge. HI/LO hold their old values until the FIX edge.
- Divide by zero: detected at START, still takes the full 33 cycles. Result: LO=all ones, HI=dividend (SRC_A unmodified). No exception.
- Signed overflow (DIV, A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0. The abs/negate path yields this naturally; it must be checked in verification.
- START while BUSY:
  - Mul/div op: the in-flight operation is abandoned and its result discarded. The new operation restarts with counter reload, and BUSY stays high continuously.
  - MTHI/MTLO: writes the register immediately. The in-flight op is also abandoned so that FIX cannot overwrite the MT value.
- No-op START: ignored; it neither aborts an in-flight op nor changes HI/LO.
- Reset mid-operation: immediate return to IDLE; HI=LO=0; BUSY=0.
- Arithmetic: subtract/add done at XLEN+1 bits; all results are truncated modulo 2^XLEN per half.

Optional Feature:
MDIV_FAST_MUL_EN:
- Defined: MULT/MULTU are computed with a single-cycle XLEN x XLEN multiplier plus sign handling. HI/LO are written at the START edge; MUL state unused; BUSY never asserts for multiplies. Divide is unchanged.
- Undefined: iterative multiply as above, with 33-cycle BUSY.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> BUSY high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. With MDIV_FAST_MUL_EN, the same values appear the next cycle and BUSY stays 0.
- DIVU A=100, B=7 -> LO=14, HI=2 after 33 cycles. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Before completion, HI/LO must still show the prior values.
- MULT started, then DIVU 9/4 issued at cycle 10 -> BUSY continuous, falls 33 cycles after the second START; LO=2, HI=1. MTLO 0x55 issued mid-DIV -> LO=0x55 immediately, BUSY drops, and no later overwrite occurs.
- RESET_N pulsed low at cycle 15 of a DIV -> BUSY=0, HI=LO=0 asynchronously. After release, a fresh MULT 6*7 gives LO=42, HI=0.
